ppa_ks_pipe_adder: RTL and testbench

Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor with valid/ready flow control. It is the next-generation replacement for the fixed-width combinational prefix adders in the arithmetic library. It is used wherever a wide add or subtract must close timing at full clock rate inside streaming datapaths. Width, prefix levels per pipeline stage, and a sideband tag are configurable. The block adds subtract mode, signed overflow and backpressure.

---
 rtl/ppa_ks_pipe_adder.sv | 161 ++++++++++++++++
 tb/tb_ppa_ks_pipe_adder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppa_ks_pipe_adder.sv
// Pipelined Kogge-Stone prefix adder/subtractor with valid/ready flow control.
// Stage R0 forms p/g, banks R1..RK each hold LPS prefix levels, Rout forms sum/flags.
module ppa_ks_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int LPS   = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int L = $clog2(WIDTH);
    localparam int K = (L + LPS - 32'sd1) / LPS;

    logic             adv_s;
    logic [WIDTH-1:0] bb_s;
    logic             ci_s;

    // Index 0 is R0, indices 1..K are the prefix register banks.
    logic [K:0]                  valid_r;
    logic [K:0]                  ci_r;
    logic [K:0][WIDTH-1:0]       p_r;
    logic [K:0][WIDTH-1:0]       g_r;
    logic [K:0][WIDTH-1:0]       gp_r;
    logic [K:0][TAG_W-1:0]       tag_r;
    logic [K:1][WIDTH-1:0]       g_nxt_s;
    logic [K:1][WIDTH-1:0]       gp_nxt_s;

    logic [WIDTH:0]   c_s;
    logic [WIDTH-1:0] sum_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic [TAG_W-1:0] out_tag_r;

    // Applies Kogge-Stone levels lo..hi (1-based) to a group/propagate vector pair.
    function automatic logic [2*WIDTH-1:0] ks_levels(
        input logic [WIDTH-1:0] g_in,
        input logic [WIDTH-1:0] p_in,
        input int               lo,
        input int               hi
    );
        logic [WIDTH-1:0] g_v;
        logic [WIDTH-1:0] p_v;
        logic [WIDTH-1:0] g_n;
        logic [WIDTH-1:0] p_n;
        int               d;
        g_v = g_in;
        p_v = p_in;
        g_n = g_in;
        p_n = p_in;
        d   = 32'sd1;
        for (int k = lo; k <= hi; k++) begin
            d = 32'sd1 <<< (k - 32'sd1);
            for (int i = 32'sd0; i < WIDTH; i++) begin
                if (i >= d) begin
                    g_n[i] = g_v[i] | (p_v[i] & g_v[i-d]);
                    p_n[i] = p_v[i] & p_v[i-d];
                end else begin
                    g_n[i] = g_v[i];
                    p_n[i] = p_v[i];
                end
            end
            g_v = g_n;
            p_v = p_n;
        end
        return {g_v, p_v};
    endfunction

    assign adv_s    = ~out_valid_r | out_ready;
    assign in_ready = adv_s;
    assign bb_s     = b ^ {WIDTH{sub}};
    assign ci_s     = cin ^ sub;

    // Prefix levels evaluated between consecutive register banks; last group may be short.
    always_comb begin
        g_nxt_s  = '0;
        gp_nxt_s = '0;
        for (int s = 32'sd1; s <= K; s++) begin
            {g_nxt_s[s], gp_nxt_s[s]} = ks_levels(g_r[s-1], gp_r[s-1],
                                                  (s - 32'sd1) * LPS + 32'sd1,
                                                  (s * LPS < L) ? s * LPS : L);
        end
    end

    // Carries from the full prefix, then sum and flags for the output bank.
    always_comb begin
        c_s    = '0;
        c_s[0] = ci_r[K];
        for (int i = 32'sd0; i < WIDTH; i++) begin
            c_s[i+1] = g_r[K][i] | (gp_r[K][i] & ci_r[K]);
        end
        sum_s = p_r[K] ^ c_s[WIDTH-1:0];
    end

    // Input capture R0 and prefix banks R1..RK, all gated by the global advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            ci_r    <= '0;
            p_r     <= '0;
            g_r     <= '0;
            gp_r    <= '0;
            tag_r   <= '0;
        end else if (adv_s) begin
            valid_r[0] <= in_valid & adv_s;
            ci_r[0]    <= ci_s;
            p_r[0]     <= a ^ bb_s;
            g_r[0]     <= a & bb_s;
            gp_r[0]    <= a ^ bb_s;
            tag_r[0]   <= tag;
            for (int s = 32'sd1; s <= K; s++) begin
                valid_r[s] <= valid_r[s-1];
                ci_r[s]    <= ci_r[s-1];
                p_r[s]     <= p_r[s-1];
                g_r[s]     <= g_nxt_s[s];
                gp_r[s]    <= gp_nxt_s[s];
                tag_r[s]   <= tag_r[s-1];
            end
        end
    end

    // Output bank Rout; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_tag_r   <= '0;
        end else if (adv_s) begin
            out_valid_r <= valid_r[K];
            sum_r       <= sum_s;
            cout_r      <= c_s[WIDTH];
            ovf_r       <= c_s[WIDTH] ^ c_s[WIDTH-1];
            out_tag_r   <= tag_r[K];
        end
    end

    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign out_tag   = out_tag_r;

endmodule

// File: tb/tb_ppa_ks_pipe_adder.sv
// Directed bench for ppa_ks_pipe_adder: three widths fed from shared stimulus,
// each scored against an arithmetic reference model.
module tb_ppa_ks_pipe_adder;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         cin;
    logic         sub;
    logic         out_ready;
    logic [127:0] a_s;
    logic [127:0] b_s;
    logic [3:0]   tag;

    logic         in_ready32, out_valid32, cout32, ovf32;
    logic [31:0]  sum32;
    logic [3:0]   otag32;
    logic         in_ready9, out_valid9, cout9, ovf9;
    logic [8:0]   sum9;
    logic [3:0]   otag9;
    logic         in_ready128, out_valid128, cout128, ovf128;
    logic [127:0] sum128;
    logic [3:0]   otag128;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [127:0] sum;
        logic         cout;
        logic         ovf;
        logic [3:0]   tag;
    } exp_t;

    exp_t q32[$];
    exp_t q9[$];
    exp_t q128[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [3:0]  tag;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    bit in_pat[512];
    bit out_pat[512];

    ppa_ks_pipe_adder #(.WIDTH(32), .LPS(2), .TAG_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .a(a_s[31:0]), .b(b_s[31:0]), .cin(cin), .sub(sub), .tag(tag),
        .out_valid(out_valid32), .out_ready(out_ready), .sum(sum32),
        .cout(cout32), .ovf(ovf32), .out_tag(otag32));

    ppa_ks_pipe_adder #(.WIDTH(9), .LPS(4), .TAG_W(4)) dut9 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready9),
        .a(a_s[8:0]), .b(b_s[8:0]), .cin(cin), .sub(sub), .tag(tag),
        .out_valid(out_valid9), .out_ready(out_ready), .sum(sum9),
        .cout(cout9), .ovf(ovf9), .out_tag(otag9));

    ppa_ks_pipe_adder #(.WIDTH(128), .LPS(1), .TAG_W(4)) dut128 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready128),
        .a(a_s), .b(b_s), .cin(cin), .sub(sub), .tag(tag),
        .out_valid(out_valid128), .out_ready(out_ready), .sum(sum128),
        .cout(cout128), .ovf(ovf128), .out_tag(otag128));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide addition, carry into the MSB recovered from the sum bit.
    function automatic exp_t model(input logic [127:0] a, input logic [127:0] b,
                                   input logic ci_in, input logic sb,
                                   input logic [3:0] tg, input int w);
        exp_t         r;
        logic [128:0] full;
        logic [127:0] mask;
        logic [127:0] bb;
        logic         ci;
        logic         cw;
        logic         cwm1;
        mask = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
        bb   = (sb ? ~b : b) & mask;
        ci   = ci_in ^ sb;
        full = {1'b0, a & mask} + {1'b0, bb} + {128'd0, ci};
        cw   = full[w];
        cwm1 = full[w-1] ^ a[w-1] ^ bb[w-1];
        r.sum  = full[127:0] & mask;
        r.cout = cw;
        r.ovf  = cw ^ cwm1;
        r.tag  = tg;
        return r;
    endfunction

    always @(negedge rst_n) begin
        q32.delete();
        q9.delete();
        q128.delete();
    end

    // Scoreboards: push on accept, pop and compare on retire, both sampled mid-cycle.
    always @(negedge clk) begin
        exp_t act;
        exp_t e;
        #2;
        if (rst_n) begin
            if (out_valid32 && out_ready) begin
                act = '{sum: {96'd0, sum32}, cout: cout32, ovf: ovf32, tag: otag32};
                if (q32.size() == 0) chk("sb32_extra", 160'd1, 160'd0);
                else begin e = q32.pop_front(); chk("sb32", act, e); end
            end
            if (out_valid9 && out_ready) begin
                act = '{sum: {119'd0, sum9}, cout: cout9, ovf: ovf9, tag: otag9};
                if (q9.size() == 0) chk("sb9_extra", 160'd1, 160'd0);
                else begin e = q9.pop_front(); chk("sb9", act, e); end
            end
            if (out_valid128 && out_ready) begin
                act = '{sum: sum128, cout: cout128, ovf: ovf128, tag: otag128};
                if (q128.size() == 0) chk("sb128_extra", 160'd1, 160'd0);
                else begin e = q128.pop_front(); chk("sb128", act, e); end
            end
            if (in_valid && in_ready32)  q32.push_back(model(a_s, b_s, cin, sub, tag, 32));
            if (in_valid && in_ready9)   q9.push_back(model(a_s, b_s, cin, sub, tag, 9));
            if (in_valid && in_ready128) q128.push_back(model(a_s, b_s, cin, sub, tag, 128));
        end
    end

    task automatic run_vec(input vec_t v);
        int cnt;
        @(negedge clk);
        a_s = {96'd0, v.a}; b_s = {96'd0, v.b};
        cin = v.cin; sub = v.sub; tag = v.tag; in_valid = 1'b1;
        cnt = 0;
        while (cnt < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            cnt++;
            if (out_valid32) break;
        end
        chk("vec_latency", cnt, 5);
        chk("vec_sum", sum32, v.sum);
        chk("vec_cout", cout32, v.cout);
        chk("vec_ovf", ovf32, v.ovf);
        chk("vec_tag", otag32, v.tag);
        @(negedge clk);
        chk("vec_pulse", out_valid32, 1'b0);
        repeat (6) @(negedge clk);
    endtask

    task automatic run_stream(input int n, input bit bubble, input int stall_at, output int ncyc);
        logic [127:0] va[128];
        logic [127:0] vb[128];
        bit           vc[128];
        bit           vs[128];
        logic [31:0]  held_sum;
        logic [3:0]   held_tag;
        int           idx;
        int           c;
        bit           acc;
        for (int i = 0; i < n; i++) begin
            va[i] = {$urandom, $urandom, $urandom, $urandom};
            vb[i] = {$urandom, $urandom, $urandom, $urandom};
            vc[i] = 1'($urandom_range(1, 0));
            vs[i] = 1'($urandom_range(1, 0));
        end
        held_sum = '0; held_tag = '0;
        idx = 0; c = 0;
        while (idx < n && c < 400) begin
            @(negedge clk);
            out_pat[c] = out_valid32;
            out_ready = !(stall_at >= 0 && c >= stall_at && c < stall_at + 10);
            a_s = va[idx]; b_s = vb[idx]; cin = vc[idx]; sub = vs[idx];
            tag = 4'(idx % 16);
            in_valid = bubble ? (c % 2 == 0) : 1'b1;
            #1;
            acc = in_valid && in_ready32;
            in_pat[c] = acc;
            if (stall_at >= 0 && c == stall_at) begin
                held_sum = sum32;
                held_tag = otag32;
            end
            if (stall_at >= 0 && c >= stall_at && c < stall_at + 10) begin
                chk("stall_in_ready", in_ready32, 1'b0);
                if (c > stall_at) begin
                    chk("stall_sum", sum32, held_sum);
                    chk("stall_tag", otag32, held_tag);
                end
            end
            if (acc) idx++;
            c++;
        end
        ncyc = c;
        repeat (12) begin
            @(negedge clk);
            out_pat[c] = out_valid32;
            in_valid = 1'b0; out_ready = 1'b1; in_pat[c] = 1'b0;
            c++;
        end
    endtask

    task automatic drain_and_check(input string name);
        int guard;
        guard = 0;
        while ((q32.size() != 0 || q9.size() != 0 || q128.size() != 0) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        #3;
        chk({name, "_q32_empty"}, q32.size(), 0);
        chk({name, "_q9_empty"}, q9.size(), 0);
        chk({name, "_q128_empty"}, q128.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ncyc;
        int ones;
        int cnt32;
        int cnt9;
        int cnt128;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h3, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 4'h4, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'h5, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h6, 32'h8000_0000, 1'b0, 1'b1};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 4'h7, 32'h0000_0001, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 4'h8, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 4'h9, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[7] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 4'hA, 32'h2345_678A, 1'b0, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 4'hB, 32'h0000_0000, 1'b1, 1'b1};
        vecs[9] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 4'hC, 32'h0000_0000, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_s = '0; b_s = '0; cin = 1'b0; sub = 1'b0; tag = 4'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid32, 1'b0);
        chk("rst_sum", sum32, 32'd0);
        chk("rst_cout", cout32, 1'b0);
        chk("rst_ovf", ovf32, 1'b0);
        chk("rst_tag", otag32, 4'd0);
        chk("rst_in_ready32", in_ready32, 1'b1);
        chk("rst_in_ready9", in_ready9, 1'b1);
        chk("rst_in_ready128", in_ready128, 1'b1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);
        drain_and_check("vec");

        run_stream(100, 1'b0, -1, ncyc);
        ones = 0;
        for (int c = 5; c < 105; c++) ones += int'(out_pat[c]);
        chk("stream_one_per_cycle", ones, 100);
        drain_and_check("stream");

        run_stream(40, 1'b0, 20, ncyc);
        drain_and_check("stall");

        run_stream(20, 1'b1, -1, ncyc);
        for (int c = 0; c < ncyc; c++) chk("bubble_pattern", out_pat[c+5], in_pat[c]);
        drain_and_check("bubble");

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_s = {4{$urandom}}; b_s = {4{$urandom}}; cin = 1'b0; sub = 1'b0;
            tag = 4'(i); in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid32", out_valid32, 1'b0);
        chk("midrst_valid9", out_valid9, 1'b0);
        chk("midrst_valid128", out_valid128, 1'b0);
        chk("midrst_sum9", sum9, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt32 = 0; cnt9 = 0; cnt128 = 0;
        repeat (15) begin
            @(negedge clk);
            cnt32 += int'(out_valid32);
            cnt9 += int'(out_valid9);
            cnt128 += int'(out_valid128);
        end
        chk("midrst_stale32", cnt32, 0);
        chk("midrst_stale9", cnt9, 0);
        chk("midrst_stale128", cnt128, 0);

        run_stream(100, 1'b0, -1, ncyc);
        drain_and_check("restream");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
